// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_pkg
// Description : Shared types and register map for the MMIO UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

    typedef logic [31:0] DataPath;
    typedef logic [31:0] DataAddrPath;
    typedef logic [7:0]  UartByte;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } UartState;

    localparam DataAddrPath UART_TXDATA_OFFSET = 32'h0;
    localparam DataAddrPath UART_STATUS_OFFSET = 32'h4;

    localparam int UART_STATUS_FULL      = 0;
    localparam int UART_STATUS_EMPTY     = 1;
    localparam int UART_STATUS_BUSY      = 2;
    localparam int UART_STATUS_OVF       = 3;
    localparam int UART_STATUS_COUNT_LSB = 4;
    localparam int UART_STATUS_COUNT_W   = 4;
    localparam int UART_STATUS_PARITY    = 8;

    // STATUS only has a 4-bit count field, so deeper FIFOs read back as 15.
    function automatic logic [3:0] satCount4(input logic [31:0] count);
        return (count > 32'd15) ? 4'hF : count[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous byte FIFO with first-word fall-through read data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  UartByte          wrData,
    output UartByte          rdData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    UartByte          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdData = r_mem[r_rdPtr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter (TXDATA push, STATUS read).
//               Define MMIO_UART_PARITY_EN to add an even parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter DataAddrPath BASE_ADDR    = 32'h100,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  DataAddrPath dataAddr,
    input  DataPath     dataOut,
    input  logic        dataWrEnable,
    output DataPath     rdData,
    output logic        hit,
    output logic        txd
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    logic               w_hitTx;
    logic               w_hitStatus;
    logic               w_pushReq;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    UartByte            w_fifoData;
    logic               w_unusedBits;

    UartState            r_state;
    UartState            w_stateNext;
    logic [c_BAUD_W-1:0] r_baudCnt;
    logic [c_BAUD_W-1:0] w_baudNext;
    logic [2:0]          r_bitIdx;
    logic [2:0]          w_bitIdxNext;
    logic [2:0]          w_bitIdxInc;
    UartByte             r_shift;
    UartByte             w_shiftNext;
    logic                r_txd;
    logic                w_txdNext;
    logic                w_bitEnd;
    logic                r_ovf;

    assign w_hitTx     = (dataAddr == BASE_ADDR + UART_TXDATA_OFFSET);
    assign w_hitStatus = (dataAddr == BASE_ADDR + UART_STATUS_OFFSET);
    assign hit         = w_hitTx || w_hitStatus;
    assign w_pushReq   = dataWrEnable && w_hitTx;
    assign w_drop      = w_pushReq && w_full && !w_pop;
    assign w_unusedBits = ^dataOut[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (w_pushReq),
        .pop    (w_pop),
        .wrData (dataOut[7:0]),
        .rdData (w_fifoData),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (dataWrEnable && w_hitStatus) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    always_comb begin
        rdData = '0;
        if (w_hitStatus) begin
            rdData[UART_STATUS_FULL]  = w_full;
            rdData[UART_STATUS_EMPTY] = w_empty;
            rdData[UART_STATUS_BUSY]  = (r_state != IDLE);
            rdData[UART_STATUS_OVF]   = r_ovf;
            rdData[UART_STATUS_COUNT_LSB +: UART_STATUS_COUNT_W] = satCount4(32'(w_count));
`ifdef MMIO_UART_PARITY_EN
            rdData[UART_STATUS_PARITY] = 1'b1;
`endif
        end
    end

    assign w_bitEnd    = (r_baudCnt == c_BAUD_LAST);
    assign w_bitIdxInc = r_bitIdx + 3'd1;
    assign txd         = r_txd;

    // txdNext follows the state being entered so txd changes on the same edge as the FSM.
    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = r_baudCnt + c_BAUD_ONE;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_txdNext    = r_txd;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_baudNext = '0;
                w_txdNext  = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_fifoData;
                    w_stateNext = START;
                    w_txdNext   = 1'b0;
                end
            end
            START: begin
                if (w_bitEnd) begin
                    w_baudNext   = '0;
                    w_bitIdxNext = '0;
                    w_txdNext    = r_shift[0];
                    w_stateNext  = DATA;
                end
            end
            DATA: begin
                if (w_bitEnd) begin
                    w_baudNext = '0;
                    if (r_bitIdx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        w_stateNext = PARITY;
                        w_txdNext   = ^r_shift;
`else
                        w_stateNext = STOP;
                        w_txdNext   = 1'b1;
`endif
                    end else begin
                        w_bitIdxNext = w_bitIdxInc;
                        w_txdNext    = r_shift[w_bitIdxInc];
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                if (w_bitEnd) begin
                    w_baudNext  = '0;
                    w_stateNext = STOP;
                    w_txdNext   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bitEnd) begin
                    w_baudNext = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_fifoData;
                        w_stateNext = START;
                        w_txdNext   = 1'b0;
                    end else begin
                        w_stateNext = IDLE;
                        w_txdNext   = 1'b1;
                    end
                end
            end
            default: begin
                w_baudNext  = '0;
                w_stateNext = IDLE;
                w_txdNext   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_baudCnt <= w_baudNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_txd     <= w_txdNext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Directed self-checking bench for mmio_uart_tx with a serial
//               line monitor that decodes frames from txd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam int CPB = 16;
`ifdef MMIO_UART_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [31:0] PARBIT = 32'h100;
`else
    localparam int NBITS = 10;
    localparam logic [31:0] PARBIT = 32'h0;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam DataAddrPath TXA = 32'h100;
    localparam DataAddrPath STA = 32'h104;
    localparam logic [31:0] ST_IDLE = 32'h2 | PARBIT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    DataAddrPath dataAddr;
    DataPath     dataOut;
    logic        dataWrEnable;
    DataPath     rdData;
    logic        hit;
    logic        txd;

    always #5 clk = ~clk;

    mmio_uart_tx dut (
        .clk          (clk),
        .rst          (rst),
        .dataAddr     (dataAddr),
        .dataOut      (dataOut),
        .dataWrEnable (dataWrEnable),
        .rdData       (rdData),
        .hit          (hit),
        .txd          (txd)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frameOf(input UartByte b);
`ifdef MMIO_UART_PARITY_EN
        return {5'b0, 1'b1, ^b, b, 1'b0};
`else
        return {6'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    int cycNum = 0;
    always @(posedge clk) cycNum <= cycNum + 1;

    // Line monitor: samples txd mid-bit on falling clock edges.
    logic [15:0]      frameQ[$];
    int               startQ[$];
    logic             mIn = 1'b0;
    int               mCnt = 0;
    int               mStart = 0;
    logic [NBITS-1:0] mBits = '0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            mIn  <= 1'b0;
            mCnt <= 0;
        end else if (!mIn) begin
            if (txd == 1'b0) begin
                mIn    <= 1'b1;
                mCnt   <= 1;
                mStart <= cycNum;
            end
        end else begin
            mCnt <= mCnt + 1;
            if ((mCnt % CPB) == CPB / 2) begin
                if (mCnt / CPB == NBITS - 1) begin
                    frameQ.push_back(16'({txd, mBits[NBITS-2:0]}));
                    startQ.push_back(mStart);
                    mIn <= 1'b0;
                end else begin
                    mBits[mCnt / CPB] <= txd;
                end
            end
        end
    end

    DataPath          s;
    int               idleCyc;
    logic [15:0]      fr;
    logic [NBITS-1:0] a5Exp;
    logic [15:0]      f07Exp;

    task automatic readStatus(output DataPath v);
        dataAddr = STA;
        #1 v = rdData;
    endtask

    task automatic busWrite(input DataAddrPath a, input DataPath d);
        @(negedge clk);
        dataAddr = a;
        dataOut = d;
        dataWrEnable = 1'b1;
        @(negedge clk);
        dataWrEnable = 1'b0;
        dataAddr = STA;
    endtask

    task automatic burst(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dataAddr = TXA;
            dataOut = DataPath'(base + i);
            dataWrEnable = 1'b1;
        end
        @(negedge clk);
        dataWrEnable = 1'b0;
        dataAddr = STA;
    endtask

    task automatic waitIdle(input int maxCyc, output int when);
        DataPath v;
        v = '1;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            readStatus(v);
            if (!v[UART_STATUS_BUSY]) break;
        end
        check("idle_reached", {31'b0, v[UART_STATUS_BUSY]}, 32'h0);
        when = cycNum;
    endtask

    task automatic checkFrames(input string tag, input int n, input int base);
        check({tag, "_frames"}, frameQ.size(), n);
        for (int i = 0; i < n && frameQ.size() > 0; i++) begin
            fr = frameQ.pop_front();
            check($sformatf("%s_byte%0d", tag, i), fr, frameOf(UartByte'(base + i)));
        end
        for (int i = 1; i < n && i < startQ.size(); i++) begin
            check($sformatf("%s_gap%0d", tag, i), startQ[i] - startQ[i-1], FRAME);
        end
    endtask

    initial begin
`ifdef MMIO_UART_PARITY_EN
        a5Exp  = 11'b1_0_10100101_0;
        f07Exp = 16'h060E;
`else
        a5Exp  = 10'b1_10100101_0;
        f07Exp = 16'h020E;
`endif
        dataAddr = STA;
        dataOut = '0;
        dataWrEnable = 1'b0;
        rst = 1'b0;

        // Reset state and decode.
        repeat (3) @(negedge clk);
        #1;
        check("rst_status", rdData, ST_IDLE);
        check("rst_hit", {31'b0, hit}, 32'h1);
        check("rst_txd", {31'b0, txd}, 32'h1);
        dataAddr = 32'h200;
        #1;
        check("miss_hit", {31'b0, hit}, 32'h0);
        check("miss_rdData", rdData, 32'h0);
        dataAddr = TXA;
        #1;
        check("txdata_hit", {31'b0, hit}, 32'h1);
        check("txdata_rdData", rdData, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        readStatus(s);
        check("post_rst_status", s, ST_IDLE);

        // Single byte A5: latency, bit pattern, busy length.
        frameQ.delete();
        startQ.delete();
        @(negedge clk);
        dataAddr = TXA;
        dataOut = 32'hA5;
        dataWrEnable = 1'b1;
        @(posedge clk);
        #1 check("a5_push_txd", {31'b0, txd}, 32'h1);
        @(negedge clk);
        dataWrEnable = 1'b0;
        dataAddr = STA;
        @(posedge clk);
        #1 check("a5_latency", {31'b0, txd}, 32'h0);
        for (int k = 0; k < NBITS; k++) begin
            repeat ((k == 0) ? CPB / 2 : CPB) @(posedge clk);
            #1 check($sformatf("a5_bit%0d", k), {31'b0, txd}, {31'b0, a5Exp[k]});
        end
        repeat (CPB / 2 - 1) @(posedge clk);
        #1 check("a5_busy_last", {31'b0, rdData[UART_STATUS_BUSY]}, 32'h1);
        @(posedge clk);
        #1 check("a5_status_after", rdData, ST_IDLE);
        check("a5_frames", frameQ.size(), 1);
        if (frameQ.size() > 0) begin
            fr = frameQ.pop_front();
            check("a5_frame", fr, frameOf(8'hA5));
        end

        // Nine back-to-back writes: all accepted, no idle gap.
        frameQ.delete();
        startQ.delete();
        burst(9, 'h30);
        readStatus(s);
        check("b9_status", s, 32'h85 | PARBIT);
        waitIdle(FRAME * 12, idleCyc);
        if (startQ.size() > 0) check("b9_total", idleCyc - startQ[0], 9 * FRAME);
        checkFrames("b9", 9, 'h30);

        // Overflow: tenth write while full is dropped; STATUS write clears ovf.
        frameQ.delete();
        startQ.delete();
        burst(10, 'h50);
        readStatus(s);
        check("ovf_status", s, 32'h8D | PARBIT);
        busWrite(STA, 32'hFF);
        readStatus(s);
        check("ovf_cleared", s, 32'h85 | PARBIT);
        waitIdle(FRAME * 12, idleCyc);
        checkFrames("ovf", 9, 'h50);

        // Reset mid-DATA of a 3-byte burst.
        frameQ.delete();
        startQ.delete();
        burst(3, 'h00);
        repeat (40) @(posedge clk);
        #2 check("rst_pre_txd", {31'b0, txd}, 32'h0);
        rst = 1'b0;
        #1 check("rst_async_txd", {31'b0, txd}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        readStatus(s);
        check("rst_mid_status", s, ST_IDLE);
        repeat (4 * FRAME) @(negedge clk);
        check("rst_mid_frames", frameQ.size(), 0);
        check("rst_mid_txd", {31'b0, txd}, 32'h1);

        // Byte 07: parity bit value, frame length and STATUS bit8.
        frameQ.delete();
        startQ.delete();
        busWrite(TXA, 32'h07);
        readStatus(s);
        check("p07_status_bit8", {31'b0, s[UART_STATUS_PARITY]}, PARBIT >> 8);
        waitIdle(FRAME * 3, idleCyc);
        if (startQ.size() > 0) check("p07_len", idleCyc - startQ[0], FRAME);
        check("p07_frames", frameQ.size(), 1);
        if (frameQ.size() > 0) begin
            fr = frameQ.pop_front();
            check("p07_frame", fr, f07Exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the core. It consumes dataAddr, dataOut and dataWrEnable.
- Writes to TXDATA push a byte into a FIFO. A serializer FSM drains the FIFO onto the txd pin, 8N1, LSB first.
- STATUS is readable combinationally, so the single-cycle core sees the read data in the same cycle.

Parameters:
- BASE_ADDR, 'h100: byte address of TXDATA; STATUS is at BASE_ADDR+4.
- FIFO_DEPTH, 8: FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 16: clk cycles per serial bit; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- dataAddr  in  DataAddrPath  CPU data address
- dataOut  in  DataPath  CPU write data; byte taken from [7:0]
- dataWrEnable  in  1  CPU write strobe
- rdData  out  DataPath  read data for the STATUS address
- hit  out  1  dataAddr matches TXDATA or STATUS; the system read mux selects rdData when set
- txd  out  1  serial output, idle high

Behaviour:
- Reset (rst=0, async) values:
  - FIFO empty; rd/wr pointers and count = 0.
  - FSM = IDLE; baud counter and bit index = 0.
  - txd = 1.
  - rdData and hit are combinational and follow dataAddr.
  - Reset asserted mid-frame aborts the frame and forces txd high immediately; queued bytes are discarded.
- Address decode: hit = (dataAddr == BASE_ADDR) or (dataAddr == BASE_ADDR+4).
- Push: occurs when dataWrEnable is high and dataAddr == BASE_ADDR.
  - If the FIFO is full, the push is silently dropped and the sticky bit ovf is set.
  - Writes to STATUS clear ovf; write data is ignored.
- STATUS read value, all other bits 0:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM != IDLE)
  - bit3 ovf
  - bits[7:4] count, saturated to 15
- rdData = 0 when dataAddr is not STATUS.
- FIFO: synchronous write; pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - A simultaneous push and pop in one cycle leaves count unchanged. This is legal when the FIFO is full, because the pop frees the slot the push uses.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop into the shift register and go to START. Latency is 1 cycle from the push cycle to txd falling.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd = shift[bitIdx] for CLKS_PER_BIT cycles per bit, 8 bits LSB first, then STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then pop again directly into START if the FIFO is non-empty, giving back-to-back frames with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
- txd is driven from a register, giving glitch-free output.
- One frame = 10*CLKS_PER_BIT cycles.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- When defined:
  - FSM gains a PARITY state between DATA and STOP, transmitting even parity (XOR of the 8 data bits).
  - Frame = 11*CLKS_PER_BIT cycles.
  - STATUS bit8 reads 1.
- When undefined: 8N1 as above; STATUS bit8 reads 0; no parity logic is synthesized.

Decomposition:
- Shared package (alongside BasicTypes/Types):
  - UartState enum {IDLE, START, DATA, STOP, PARITY}
  - UART_STATUS_* bit index constants
  - UART_TXDATA_OFFSET = 0, UART_STATUS_OFFSET = 4
  - UartByte typedef, logic[7:0]
- One sub-module, uart_tx_fifo: parameterized sync FIFO with push/pop/full/empty/count.
- The FSM and decode stay in mmio_uart_tx.

Test Plan:
- Reset, then read STATUS at 'h104: rdData='h2 (empty=1), hit=1, txd=1. Read at 'h200: hit=0, rdData=0.
- Write 'hA5 to 'h100, CLKS_PER_BIT=16:
  - txd falls 1 cycle later.
  - Sampled mid-bit: 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop).
  - busy=1 for 160 cycles, then STATUS='h2.
- Write 9 bytes in consecutive cycles with FIFO_DEPTH=8:
  - The first pop frees a slot, so all 9 are accepted; ovf=0.
  - Frames are back-to-back with no idle high beyond the stop bits; total 1440 cycles.
- Fill the FIFO while the FSM is busy (8 entries plus 1 in flight), then write once more:
  - STATUS shows full=1, ovf=1, count=8.
  - Write to 'h104 clears ovf.
  - Only 9 frames are emitted.
- Assert rst low mid-DATA of a 3-byte burst:
  - txd=1 asynchronously.
  - After release, STATUS='h2 and no further frames are emitted.
- With MMIO_UART_PARITY_EN, write 'h07:
  - Parity bit = 1.
  - Frame length is 176 cycles.
  - STATUS bit8 = 1.
